adder_acc_seq: RTL and testbench

- Sequential accumulation stage directly downstream of the combinational two-input adder.
- Consumes the adder's (DATA_WIDTH+1)-bit sum stream and accumulates a programmable number of valid sums into one wider result.
- Presents that result to the next stage (reduction network / output buffer) with a valid/ready handshake.
- Used to fold partial sums over multiple cycles when the spatial adder tree is narrower than the reduction.

---
 rtl/adder_acc_seq.sv | 124 ++++++++++++
 tb/tb_adder_acc_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_acc_seq.sv
// adder_acc_seq: folds a programmable number of unsigned adder sums into one
// wider result and hands it downstream over a valid/ready handshake.
module adder_acc_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 9,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH:0]   i_data_bus,
  output logic                  o_ready,
  input  logic                  i_en,
  input  logic [CNT_WIDTH-1:0]  i_num,
  output logic                  o_valid,
  output logic [ACC_WIDTH-1:0]  o_data_bus,
  input  logic                  i_ready,
  output logic                  o_overflow,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_num_lat;
  logic                   r_ovf;

  logic                   w_accept;
  logic [ACC_WIDTH-1:0]   w_data_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [CNT_WIDTH-1:0]   w_num_eff;

  // Unsigned zero-extension of an upstream sum to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] zext(input logic [DATA_WIDTH:0] d);
    return ACC_WIDTH'(d);
  endfunction

  // Wrapping add; the extra MSB is the carry out of bit ACC_WIDTH-1.
  function automatic logic [ACC_WIDTH:0] add_wrap(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign o_ready    = i_en & (r_state != S_DONE);
  assign w_accept   = i_valid & o_ready;
  assign w_data_ext = zext(i_data_bus);
  assign w_sum      = add_wrap(r_acc, w_data_ext);
  assign w_cnt_inc  = r_cnt + CNT_WIDTH'(1);
  // A group size of zero is treated as one so a group always terminates.
  assign w_num_eff  = (i_num == '0) ? CNT_WIDTH'(1) : i_num;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: close the group on the final accepted sum, leave DONE on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_num_eff == CNT_WIDTH'(1)) ? S_DONE : S_ACC;
      S_ACC:  if (w_accept && (w_cnt_inc == r_num_lat)) w_state_nxt = S_DONE;
      S_DONE: if (i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, count, latched group size and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_num_lat <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_acc     <= w_data_ext;
          r_cnt     <= CNT_WIDTH'(1);
          r_num_lat <= w_num_eff;
          r_ovf     <= 1'b0;
        end
        S_ACC: if (w_accept) begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          r_cnt <= w_cnt_inc;
          r_ovf <= r_ovf | w_sum[ACC_WIDTH];
        end
        S_DONE: if (i_ready) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end
        default: begin
          r_acc <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: the running accumulator is only visible while a result is presented.
  always_comb begin
    o_valid    = 1'b0;
    o_data_bus = '0;
    o_overflow = 1'b0;
    o_busy     = (r_state != S_IDLE);
    if (r_state == S_DONE) begin
      o_valid    = 1'b1;
      o_data_bus = r_acc;
      o_overflow = r_ovf;
    end
  end

endmodule

// File: tb/tb_adder_acc_seq.sv
// Directed bench for adder_acc_seq, built with an 18-bit accumulator so the
// wrap case is reachable with 17-bit sums.
module tb_adder_acc_seq;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [DW:0]   i_data_bus;
  logic          o_ready;
  logic          i_en;
  logic [CW-1:0] i_num;
  logic          o_valid;
  logic [AW-1:0] o_data_bus;
  logic          i_ready;
  logic          o_overflow;
  logic          o_busy;

  int total;
  int bad;

  adder_acc_seq #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_ready(o_ready), .i_en(i_en), .i_num(i_num), .o_valid(o_valid),
    .o_data_bus(o_data_bus), .i_ready(i_ready), .o_overflow(o_overflow),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW:0] d);
    i_valid    = 1'b1;
    i_data_bus = d;
    cycle();
    i_valid    = 1'b0;
  endtask

  // Checks a presented result: valid high, value and overflow flag, o_ready low.
  task automatic expect_result(input string name, input logic [AW-1:0] d, input logic ov);
    total++;
    if (o_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", name, o_valid); end
    total++;
    if (o_data_bus !== d) begin bad++; $display("FAIL %s_data got=%0d want=%0d", name, o_data_bus, d); end
    total++;
    if (o_overflow !== ov) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, o_overflow, ov); end
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL %s_ready got=%b want=0", name, o_ready); end
  endtask

  task automatic expect_idle(input string name);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL %s_valid got=%b want=0", name, o_valid); end
    total++;
    if (o_data_bus !== '0) begin bad++; $display("FAIL %s_data got=%0d want=0", name, o_data_bus); end
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b want=0", name, o_busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_en = 1'b1; i_valid = 1'b1; i_data_bus = 17'd5; i_num = 8'd1; i_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0; i_valid = 1'b0;
    #1;
    expect_idle("reset");
    total++;
    if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", o_overflow); end
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_en1 got=%b want=1", o_ready); end
    i_en = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_en0 got=%b want=0", o_ready); end
    i_en = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    i_num = 8'd4; i_ready = 1'b1;
    send(17'd10);
    send(17'd20);
    send(17'd30);
    total++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL basic_mid valid=%b busy=%b want valid=0 busy=1", o_valid, o_busy);
    end
    send(17'd40);
    expect_result("basic", 18'd100, 1'b0);
    // Sum offered while in DONE must be ignored even as the handshake completes.
    i_valid = 1'b1; i_data_bus = 17'd7;
    cycle();
    i_valid = 1'b0;
    #1;
    expect_idle("basic_after");
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL basic_next_ready got=%b want=1", o_ready); end
    // A single-sum group right away proves the DONE-cycle sum was not latched.
    i_num = 8'd1;
    send(17'd9);
    expect_result("basic_next", 18'd9, 1'b0);
    cycle();
  endtask

  task automatic test_gaps_stall();
    i_num = 8'd3; i_ready = 1'b0;
    send(17'd1);
    for (int k = 0; k < 3; k++) cycle();
    total++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0 || o_data_bus !== '0) begin
      bad++; $display("FAIL gap_hold busy=%b valid=%b data=%0d want 1 0 0", o_busy, o_valid, o_data_bus);
    end
    send(17'd2);
    i_en = 1'b0; i_valid = 1'b1; i_data_bus = 17'd99;
    #1;
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", o_ready); end
    cycle();
    cycle();
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_no_accept got=%b want=0", o_valid); end
    i_en = 1'b1;
    send(17'd3);
    i_valid = 1'b1; i_data_bus = 17'd50;
    for (int k = 0; k < 5; k++) begin
      expect_result("hold", 18'd6, 1'b0);
      cycle();
    end
    expect_result("hold_last", 18'd6, 1'b0);
    i_valid = 1'b0; i_ready = 1'b1;
    cycle();
    expect_idle("hold_release");
  endtask

  task automatic test_group_size();
    i_ready = 1'b1;
    i_num = 8'd0;
    send(17'd65535);
    expect_result("num0", 18'd65535, 1'b0);
    cycle();
    i_num = 8'd1;
    send(17'd65535);
    expect_result("num1", 18'd65535, 1'b0);
    cycle();
    i_num = 8'd255;
    for (int k = 0; k < 254; k++) send(17'd1);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL num255_early got=%b want=0", o_valid); end
    send(17'd1);
    expect_result("num255", 18'd255, 1'b0);
    cycle();
    i_num = 8'd3;
    send(17'd5);
    i_num = 8'd2;
    send(17'd6);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL num_change_early got=%b want=0", o_valid); end
    send(17'd7);
    expect_result("num_change", 18'd18, 1'b0);
    cycle();
  endtask

  task automatic test_overflow();
    i_ready = 1'b1; i_num = 8'd3;
    send(17'd131071);
    send(17'd131071);
    send(17'd2);
    expect_result("ovf", 18'd0, 1'b1);
    cycle();
    i_num = 8'd2;
    send(17'd1);
    send(17'd1);
    expect_result("ovf_clear", 18'd2, 1'b0);
    cycle();
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1; i_num = 8'd4;
    send(17'd1);
    send(17'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    expect_idle("rst_acc");
    i_num = 8'd2;
    send(17'd7);
    send(17'd8);
    expect_result("rst_acc_next", 18'd15, 1'b0);
    cycle();
    i_ready = 1'b0;
    send(17'd3);
    send(17'd4);
    expect_result("rst_done_pre", 18'd7, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    expect_idle("rst_done");
    i_ready = 1'b1;
    cycle();
    cycle();
    expect_idle("rst_done_later");
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_en = 1'b1; i_num = '0; i_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps_stall();
    test_group_size();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
